// File: rtl/poly_ctrl_pkg.sv
// ============================================================================
// Module : poly_ctrl_pkg
// Brief  : Shared op/state codes and responder FSM type for the op sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package poly_ctrl_pkg;

   localparam logic [2:0] OP_INIT   = 3'd0;
   localparam logic [2:0] OP_RUN    = 3'd1;
   localparam logic [2:0] OP_RESULT = 3'd2;
   localparam logic [2:0] OP_DONE   = 3'd3;
   localparam logic [2:0] OP_CLRERR = 3'd4;
   localparam logic [2:0] OP_APPLY  = 3'd5;
   localparam logic [2:0] OP_RERUN  = 3'd6;

   localparam logic [2:0] ST_CAL    = 3'd2;
   localparam logic [2:0] ST_REPCLK = 3'd3;
   localparam logic [2:0] ST_REPVLD = 3'd4;
   localparam logic [2:0] ST_REVMB  = 3'd5;
   localparam logic [2:0] ST_REPMB  = 3'd6;

   localparam int TIMEOUT_CYC_DEF = 64;

   typedef enum logic [1:0] {
      RSP_IDLE   = 2'd0,
      RSP_LOCAL  = 2'd1,
      RSP_REQ    = 2'd2,
      RSP_REPORT = 2'd3
   } rsp_state_e;

   // Ops that need the polynomial datapath; everything else is answered locally.
   function automatic logic op_is_remote(input logic [2:0] op);
      return (op == OP_RUN) || (op == OP_APPLY) || (op == OP_RERUN);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mx_watchdog.sv
// ============================================================================
// Module : mx_watchdog
// Brief  : Saturating request watchdog with synchronous clear and expiry flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mx_watchdog #(
   parameter int LIMIT = 64,
   parameter int TO_W  = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [TO_W-1:0] C_LAST = TO_W'(LIMIT - 1);
   localparam logic [TO_W-1:0] C_SAT  = '1;

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != C_SAT)) begin
         r_cnt <= r_cnt + TO_W'(1);
      end
   end

   // Count holds k-1 in the k-th enabled cycle, so this fires on the LIMIT-th.
   assign o_expired = i_en && (r_cnt >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/mx_op_responder.sv
// ============================================================================
// Module : mx_op_responder
// Brief  : Op-sequencer responder; runs ops locally or via datapath req/ack.
//          Optional MX_OP_STATS_EN adds saturating op/error/abort counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mx_op_responder
   import poly_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int TO_W        = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mx_start,
   input  logic [2:0] mx_op,
   input  logic [2:0] mx_state,
   output logic       mx_done,
   output logic       success,
   output logic       abort,
   output logic       busy,
   output logic       overrun,
   output logic       hw_req,
   output logic [2:0] hw_mode,
   input  logic       hw_ack,
   input  logic       hw_err
`ifdef MX_OP_STATS_EN
   ,
   output logic [15:0] stat_ops,
   output logic [15:0] stat_errs,
   output logic [15:0] stat_aborts
`endif
);

   rsp_state_e r_state, w_state_nxt;
   logic [2:0] r_op,      w_op_nxt;
   logic [2:0] r_mode,    w_mode_nxt;
   logic       r_busy,    w_busy_nxt;
   logic       r_done,    w_done_nxt;
   logic       r_success, w_success_nxt;
   logic       r_abort,   w_abort_nxt;
   logic       r_overrun, w_overrun_nxt;
   logic       r_req,     w_req_nxt;
   logic       r_err,     w_err_nxt;
   logic       w_expired;

   mx_watchdog #(
      .LIMIT (TIMEOUT_CYC),
      .TO_W  (TO_W)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (r_state != RSP_REQ),
      .i_en      (r_state == RSP_REQ),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= RSP_IDLE;
         r_op      <= 3'd0;
         r_mode    <= 3'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_success <= 1'b0;
         r_abort   <= 1'b0;
         r_overrun <= 1'b0;
         r_req     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_op      <= w_op_nxt;
         r_mode    <= w_mode_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_success <= w_success_nxt;
         r_abort   <= w_abort_nxt;
         r_overrun <= w_overrun_nxt;
         r_req     <= w_req_nxt;
         r_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_op_nxt      = r_op;
      w_mode_nxt    = r_mode;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_success_nxt = r_success;
      w_abort_nxt   = 1'b0;
      w_overrun_nxt = r_overrun;
      w_req_nxt     = r_req;
      w_err_nxt     = r_err;

      case (r_state)
         RSP_IDLE: begin
            if (mx_start) begin
               w_op_nxt   = mx_op;
               w_mode_nxt = mx_state;
               w_busy_nxt = 1'b1;
               if (op_is_remote(mx_op)) begin
                  w_state_nxt = RSP_REQ;
                  w_req_nxt   = 1'b1;
               end else begin
                  w_state_nxt = RSP_LOCAL;
               end
            end
         end
         RSP_LOCAL: begin
            case (r_op)
               OP_INIT: begin
                  w_err_nxt     = 1'b0;
                  w_success_nxt = 1'b1;
               end
               OP_DONE:   w_success_nxt = 1'b1;
               OP_RESULT: w_success_nxt = !r_err;
               OP_CLRERR: begin
                  w_err_nxt     = 1'b0;
                  w_overrun_nxt = 1'b0;
                  w_success_nxt = 1'b1;
               end
               default:   w_success_nxt = 1'b0;
            endcase
            w_done_nxt  = 1'b1;
            w_state_nxt = RSP_REPORT;
         end
         RSP_REQ: begin
            // An ack landing on the expiry cycle is a real completion, not an abort.
            if (hw_ack) begin
               w_req_nxt     = 1'b0;
               w_err_nxt     = hw_err;
               w_success_nxt = !hw_err;
               w_done_nxt    = 1'b1;
               w_state_nxt   = RSP_REPORT;
            end else if (w_expired) begin
               w_req_nxt     = 1'b0;
               w_err_nxt     = 1'b1;
               w_success_nxt = 1'b0;
               w_abort_nxt   = 1'b1;
               w_done_nxt    = 1'b1;
               w_state_nxt   = RSP_REPORT;
            end
         end
         RSP_REPORT: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = RSP_IDLE;
         end
         default: w_state_nxt = RSP_IDLE;
      endcase

      // A new strobe outranks a CLRERR completing in the same cycle.
      if (mx_start && (r_state != RSP_IDLE)) begin
         w_overrun_nxt = 1'b1;
      end
   end

   assign mx_done = r_done;
   assign success = r_success;
   assign abort   = r_abort;
   assign busy    = r_busy;
   assign overrun = r_overrun;
   assign hw_req  = r_req;
   assign hw_mode = r_mode;

`ifdef MX_OP_STATS_EN
   logic [15:0] r_stat_ops, r_stat_errs, r_stat_aborts;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_ops    <= 16'd0;
         r_stat_errs   <= 16'd0;
         r_stat_aborts <= 16'd0;
      end else begin
         if (r_done && (r_stat_ops != 16'hFFFF)) begin
            r_stat_ops <= r_stat_ops + 16'd1;
         end
         if (r_done && !r_success && (r_stat_errs != 16'hFFFF)) begin
            r_stat_errs <= r_stat_errs + 16'd1;
         end
         if (r_abort && (r_stat_aborts != 16'hFFFF)) begin
            r_stat_aborts <= r_stat_aborts + 16'd1;
         end
      end
   end

   assign stat_ops    = r_stat_ops;
   assign stat_errs   = r_stat_errs;
   assign stat_aborts = r_stat_aborts;
`endif

endmodule

`default_nettype wire

// File: doc/mx_op_responder.md
Name: mx_op_responder

Overview:
- Responder end of the op-sequencer handshake: accepts one op command per `mx_start` pulse, runs it against the evaluation datapath and returns `mx_done` with `success`/`abort`.
- Sits between the state transition handler (initiator) and the polynomial datapath, which it drives through a req/ack pair.
- Owns the sticky result used by RESULT and CLRERR, and the watchdog that produces `abort`.

Parameters:
- TIMEOUT_CYC, 64: cycles `hw_req` may stay high without `hw_ack` before abort (minimum 2).
- TO_W, 7: width of the watchdog counter; must satisfy 2**TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mx_start  in  1  one-cycle command strobe from the initiator.
- mx_op  in  3  op code (INIT=0, RUN=1, RESULT=2, DONE=3, CLRERR=4, APPLY=5, RERUN=6); valid with mx_start.
- mx_state  in  3  module state (CAL=2, REPCLK=3, REPVLD=4, REVMB=5, REPMB=6); valid with mx_start.
- mx_done  out  1  one-cycle completion strobe.
- success  out  1  op result; valid while mx_done=1, held until the next mx_done.
- abort  out  1  one-cycle strobe coincident with mx_done when the watchdog fired.
- busy  out  1  command in progress.
- overrun  out  1  sticky: mx_start arrived while busy; cleared by a CLRERR op or reset.
- hw_req  out  1  datapath request level.
- hw_mode  out  3  latched mx_state, forwarded to the datapath while hw_req=1.
- hw_ack  in  1  datapath completion strobe.
- hw_err  in  1  datapath error; sampled only with hw_ack.

Behaviour:
- Reset (async assert, sync deassert handled upstream): FSM=IDLE; mx_done, success, abort, busy, overrun, hw_req=0; hw_mode=0; sticky result_err=0; watchdog=0.
- FSM states: IDLE, LOCAL, REQ, REPORT.
- IDLE:
  - On mx_start, latch mx_op/mx_state and set busy=1 in the next cycle.
  - RUN/APPLY/RERUN go to REQ; all other ops go to LOCAL.
- LOCAL (exactly 1 cycle):
  - INIT: result_err=0, success=1.
  - DONE: success=1.
  - RESULT: success=!result_err.
  - CLRERR: result_err=0, overrun=0, success=1.
  - Undefined op code: success=0.
  - Then go to REPORT.
- REQ:
  - hw_req=1 and hw_mode=latched state from the first REQ cycle.
  - Watchdog increments each cycle.
  - hw_ack: drop hw_req next cycle, result_err<=hw_err, success=!hw_err, go to REPORT.
  - Watchdog reaches TIMEOUT_CYC with no ack: drop hw_req, result_err=1, success=0, abort=1, go to REPORT.
  - hw_ack in the same cycle as the timeout: the ack wins, no abort.
- REPORT: mx_done=1 for one cycle, busy=0 in the following cycle, return to IDLE.
- Latency:
  - LOCAL ops: mx_start at cycle N gives mx_done at N+2.
  - REQ ops: mx_done 1 cycle after the hw_ack cycle.
- mx_start while busy (any state except IDLE): ignored and overrun<=1. A CLRERR issued later clears overrun.
- mx_start in the REPORT cycle is also an overrun; the initiator must wait for mx_done.
- hw_ack while not in REQ: ignored.
- Watchdog clears on entry to REQ; it saturates and never wraps.
- rst_n low mid-operation: all outputs return to reset values immediately and any pending request is abandoned (hw_req drops asynchronously).

Optional Feature:
- Macro: MX_OP_STATS_EN.
- When defined, adds 16-bit saturating outputs:
  - stat_ops: incremented on every mx_done.
  - stat_errs: incremented on mx_done with success=0.
  - stat_aborts: incremented on abort.
  - All three clear on reset only.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package poly_ctrl_pkg holds:
  - op-code and state-code localparams (3-bit, values as above);
  - the responder FSM enum;
  - default TIMEOUT_CYC.
- The initiator imports the same package.
- Sub-module mx_watchdog (clear, enable, saturating count, expired flag) is the one natural split; the rest stays flat.

Test Plan:
- Reset then INIT (mx_state=CAL) at cycle 10 -> mx_done at 12, success=1, hw_req never asserted.
- RUN with mx_state=REPVLD; hw_ack at req cycle 5 with hw_err=1 -> hw_mode=4 during req, mx_done 1 cycle later with success=0; then RESULT -> success=0; CLRERR -> success=1; RESULT -> success=1.
- APPLY with no hw_ack, TIMEOUT_CYC=8 -> hw_req high 8 cycles, then mx_done+abort, success=0; late hw_ack afterwards is ignored.
- hw_ack coincident with the timeout cycle -> mx_done, abort=0, success=!hw_err.
- Second mx_start during REQ -> ignored, overrun=1, first op completes normally; CLRERR clears overrun.
- rst_n pulled low while hw_req=1 -> hw_req, busy and mx_done go low in the same cycle; the next RUN completes normally. With MX_OP_STATS_EN, also check stat_ops, stat_errs and stat_aborts after each scenario.
